cell_array_ctrl: RTL

Command-side initiator for the compute-in-memory row array. It accepts one decoded command per handshake (write, read, compute or copy) and converts it into the array's one-hot row selects, write enables, FA opcode and data buses. It then captures the array's read bus and overflow flags and returns one response per command. It sits between the processor issue stage and the row array.

---
 rtl/cell_ctrl_pkg.sv | 48 ++++
 rtl/row_onehot_dec.sv | 22 ++
 rtl/cell_array_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cell_ctrl_pkg.sv
// Shared types and constants for the cell array command controller.
//   op_e     : decoded command opcode (WRITE, READ, COMPUTE, COPY)
//   state_e  : controller sequencing state
//   FA_*     : full-adder opcode enables as presented on arr_op_fa
//   SEL_*    : positions of the row-select buses in the decoder bank
//   uses_ra/uses_rb/uses_rd : which row indices an opcode consumes
package cell_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_COPY    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DRIVE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

    localparam logic [3:0] FA_SUM = 4'b0001;
    localparam logic [3:0] FA_AND = 4'b0010;
    localparam logic [3:0] FA_XOR = 4'b0100;
    localparam logic [3:0] FA_OR  = 4'b1000;

    // One one-hot decoder per select bus driven towards the array.
    localparam int NSEL      = 5;
    localparam int SEL_RD_UP = 0;
    localparam int SEL_RD_DN = 1;
    localparam int SEL_WR_UP = 2;
    localparam int SEL_WR_DN = 3;
    localparam int SEL_WR_EN = 4;

    function automatic logic uses_ra(input op_e op);
        return op != OP_WRITE;
    endfunction

    function automatic logic uses_rb(input op_e op);
        return op == OP_COMPUTE;
    endfunction

    function automatic logic uses_rd(input op_e op);
        return op != OP_READ;
    endfunction

endpackage

// File: rtl/row_onehot_dec.sv
// Row index to one-hot select decoder.
//   idx    : row index
//   en     : decode enable
//   onehot : bit idx set when en=1 and idx < ROWS, otherwise all zero
module row_onehot_dec #(
    parameter int AW   = 5,
    parameter int ROWS = 32
) (
    input  logic [AW-1:0]   idx,
    input  logic            en,
    output logic [ROWS-1:0] onehot
);

    // An index at or beyond ROWS matches no row, so it decodes to zero.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign onehot[gi] = en && (int'(idx) == gi);
        end
    endgenerate

endmodule

// File: rtl/cell_array_ctrl.sv
// Command-side initiator for the compute-in-memory row array.
// Accepts one command per handshake, drives the array for exactly one cycle
// (all array outputs registered), captures the read bus / overflow flag one
// cycle later and holds a response until it is accepted.
//
// Ports:
//   clk, rst (async, active low)
//   cmd_valid/cmd_ready, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_fa, cmd_cin, cmd_data
//   rsp_valid/rsp_ready, rsp_data, rsp_ovf, rsp_err, busy
//   arr_rd_addr_up/dn, arr_wr_addr_up/dn, arr_wr_en : one-hot row selects
//   arr_op_fa, arr_carry_in, arr_data_in_up/dn, arr_rd_in_up/dn : array drive
//   arr_rd_out_up/dn, arr_overflow : array returns
//
// Optional build macro CELL_CTRL_OVF_STICKY_EN adds ovf_sticky (accumulated
// per-row overflow over COMPUTE captures) and its synchronous clear ovf_clr.
module cell_array_ctrl
    import cell_ctrl_pkg::*;
#(
    parameter int COLS = 32,
    parameter int ROWS = 32,
    parameter int AW   = $clog2(ROWS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [AW-1:0]   cmd_ra,
    input  logic [AW-1:0]   cmd_rb,
    input  logic [AW-1:0]   cmd_rd,
    input  logic [3:0]      cmd_fa,
    input  logic            cmd_cin,
    input  logic [COLS-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [COLS-1:0] rsp_data,
    output logic            rsp_ovf,
    output logic            rsp_err,
    output logic            busy,
    output logic [ROWS-1:0] arr_rd_addr_up,
    output logic [ROWS-1:0] arr_rd_addr_dn,
    output logic [ROWS-1:0] arr_wr_addr_up,
    output logic [ROWS-1:0] arr_wr_addr_dn,
    output logic [ROWS-1:0] arr_wr_en,
    output logic [3:0]      arr_op_fa,
    output logic            arr_carry_in,
    output logic [COLS-1:0] arr_data_in_up,
    output logic [COLS-1:0] arr_data_in_dn,
    output logic [COLS-1:0] arr_rd_in_up,
    output logic [COLS-1:0] arr_rd_in_dn,
    input  logic [COLS-1:0] arr_rd_out_up,
    input  logic [COLS-1:0] arr_rd_out_dn,
    input  logic [ROWS-1:0] arr_overflow
`ifdef CELL_CTRL_OVF_STICKY_EN
    ,
    output logic [ROWS-1:0] ovf_sticky,
    input  logic            ovf_clr
`endif
);

    state_e state_reg, state_next;
    op_e    op_reg;
    logic [AW-1:0] rd_reg;

    logic [COLS-1:0] rsp_data_reg;
    logic            rsp_ovf_reg;
    logic            rsp_err_reg;

    logic [ROWS-1:0] rd_addr_up_reg, rd_addr_dn_reg;
    logic [ROWS-1:0] wr_addr_up_reg, wr_addr_dn_reg, wr_en_reg;
    logic [3:0]      op_fa_reg;
    logic            carry_in_reg;
    logic [COLS-1:0] data_in_up_reg;

    op_e  cmd_op_e;
    logic accept;
    logic launch;
    logic cmd_err;
    logic ra_bad, rb_bad, rd_bad;

    assign cmd_op_e = op_e'(cmd_op);
    assign accept   = (state_reg == ST_IDLE) && cmd_valid;

    // Only the indices an opcode actually consumes are range-checked.
    assign ra_bad  = int'(cmd_ra) >= ROWS;
    assign rb_bad  = int'(cmd_rb) >= ROWS;
    assign rd_bad  = int'(cmd_rd) >= ROWS;
    assign cmd_err = (uses_ra(cmd_op_e) && ra_bad) ||
                     (uses_rb(cmd_op_e) && rb_bad) ||
                     (uses_rd(cmd_op_e) && rd_bad);
    assign launch  = accept && !cmd_err;

    // ------------------------------------------------------------------
    // Select decoders: decoded straight from the command on the accepting
    // edge so the registered selects are live for exactly the DRIVE cycle.
    // ------------------------------------------------------------------
    logic [AW-1:0]   sel_idx [NSEL];
    logic [NSEL-1:0] sel_en;
    logic [ROWS-1:0] sel_vec [NSEL];

    assign sel_idx[SEL_RD_UP] = cmd_ra;
    assign sel_idx[SEL_RD_DN] = cmd_rb;
    assign sel_idx[SEL_WR_UP] = cmd_rd;
    assign sel_idx[SEL_WR_DN] = cmd_rd;
    assign sel_idx[SEL_WR_EN] = cmd_rd;

    assign sel_en[SEL_RD_UP] = launch && uses_ra(cmd_op_e);
    assign sel_en[SEL_RD_DN] = launch && (cmd_op_e == OP_COMPUTE);
    assign sel_en[SEL_WR_UP] = launch && ((cmd_op_e == OP_WRITE) || (cmd_op_e == OP_COMPUTE));
    assign sel_en[SEL_WR_DN] = launch && (cmd_op_e == OP_COPY);
    assign sel_en[SEL_WR_EN] = launch && uses_rd(cmd_op_e);

    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_sel
            row_onehot_dec #(
                .AW   (AW),
                .ROWS (ROWS)
            ) u_dec (
                .idx    (sel_idx[gi]),
                .en     (sel_en[gi]),
                .onehot (sel_vec[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                // Rejected commands never touch the array.
                if (cmd_valid) begin
                    state_next = cmd_err ? ST_RESP : ST_DRIVE;
                end
            end
            ST_DRIVE:   state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [ROWS-1:0] ovf_shift;
    assign ovf_shift = arr_overflow >> rd_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg         <= OP_WRITE;
            rd_reg         <= '0;
            rsp_data_reg   <= '0;
            rsp_ovf_reg    <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rd_addr_up_reg <= '0;
            rd_addr_dn_reg <= '0;
            wr_addr_up_reg <= '0;
            wr_addr_dn_reg <= '0;
            wr_en_reg      <= '0;
            op_fa_reg      <= '0;
            carry_in_reg   <= 1'b0;
            data_in_up_reg <= '0;
        end else begin
            // Selects are zero unless this edge launches a command, which
            // bounds array activity to the single DRIVE cycle.
            rd_addr_up_reg <= sel_vec[SEL_RD_UP];
            rd_addr_dn_reg <= sel_vec[SEL_RD_DN];
            wr_addr_up_reg <= sel_vec[SEL_WR_UP];
            wr_addr_dn_reg <= sel_vec[SEL_WR_DN];
            wr_en_reg      <= sel_vec[SEL_WR_EN];
            op_fa_reg      <= (launch && cmd_op_e == OP_COMPUTE) ? cmd_fa : 4'b0000;
            carry_in_reg   <= launch && (cmd_op_e == OP_COMPUTE) && cmd_cin;
            data_in_up_reg <= (launch && cmd_op_e == OP_WRITE) ? cmd_data : '0;

            if (accept) begin
                op_reg      <= cmd_op_e;
                rd_reg      <= cmd_rd;
                rsp_err_reg <= cmd_err;
            end

            if (state_reg == ST_CAPTURE) begin
                rsp_data_reg <= (op_reg == OP_READ || op_reg == OP_COPY) ? arr_rd_out_up : '0;
                rsp_ovf_reg  <= (op_reg == OP_COMPUTE) ? ovf_shift[0] : 1'b0;
            end

            if (state_reg == ST_RESP && rsp_ready) begin
                rsp_data_reg <= '0;
                rsp_ovf_reg  <= 1'b0;
                rsp_err_reg  <= 1'b0;
            end
        end
    end

`ifdef CELL_CTRL_OVF_STICKY_EN
    logic [ROWS-1:0] ovf_sticky_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky_reg <= '0;
        end else if (ovf_clr) begin
            ovf_sticky_reg <= '0;
        end else if (state_reg == ST_CAPTURE && op_reg == OP_COMPUTE) begin
            ovf_sticky_reg <= ovf_sticky_reg | arr_overflow;
        end
    end

    assign ovf_sticky = ovf_sticky_reg;
`endif

    // The down read channel is never returned to the issue stage.
    logic unused_rd_out_dn;
    assign unused_rd_out_dn = ^arr_rd_out_dn;

    assign rsp_data       = rsp_data_reg;
    assign rsp_ovf        = rsp_ovf_reg;
    assign rsp_err        = rsp_err_reg;
    assign arr_rd_addr_up = rd_addr_up_reg;
    assign arr_rd_addr_dn = rd_addr_dn_reg;
    assign arr_wr_addr_up = wr_addr_up_reg;
    assign arr_wr_addr_dn = wr_addr_dn_reg;
    assign arr_wr_en      = wr_en_reg;
    assign arr_op_fa      = op_fa_reg;
    assign arr_carry_in   = carry_in_reg;
    assign arr_data_in_up = data_in_up_reg;
    assign arr_data_in_dn = '0;
    assign arr_rd_in_up   = '0;
    assign arr_rd_in_dn   = '0;

endmodule
